// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: sequences R/I-arith, load, store and BEQ over a shared
// memory port with a req/ready handshake and an optional request timeout.
module multicycle_control_unit #(
    parameter int unsigned N           = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] instr,
    input  logic         zero,
    input  logic         mem_ready,
    output logic         mem_req,
    output logic         mem_we,
    output logic         i_or_d,
    output logic         ir_write,
    output logic         pc_write,
    output logic         pc_src,
    output logic         alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   alu_op,
    output logic         mem_to_reg,
    output logic         reg_write,
    output logic         instr_done,
    output logic         illegal,
    output logic         bus_error,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StBranch = 3'd6,
        StBad    = 3'd7
    } state_e;

    localparam logic [6:0] OpcReg    = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

    // A zero-width counter is not legal, so the disabled case still keeps one bit.
    localparam int unsigned CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] ToLast = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    opcode;
    logic          is_load, is_store;
    logic          req_phase;
    logic          timeout;
    logic          unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^instr[N-1:7];
    assign is_load      = (opcode == OpcLoad);
    assign is_store     = (opcode == OpcStore);
    assign req_phase    = (state_q == StFetch) || (state_q == StMem);

    // Fires on the MEM_TIMEOUT-th consecutive request cycle that still lacks mem_ready.
    assign timeout = (MEM_TIMEOUT != 0) && req_phase && !mem_ready && (cnt_q == ToLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = AluAdd;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_error  = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end

            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SrcBFour;
                alu_op    = AluAdd;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = StFetch;
                end
            end

            StDecode: begin
                // PC + imm lands in ALUOut ahead of a possible branch.
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                case (opcode)
                    OpcReg, OpcImm, OpcLoad, OpcStore: state_d = StExec;
                    OpcBranch:                         state_d = StBranch;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end

            StExec: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OpcReg: begin
                        alu_src_b = SrcBReg;
                        alu_op    = AluFunct;
                        state_d   = StWb;
                    end
                    OpcImm: begin
                        alu_src_b = SrcBImm;
                        alu_op    = AluFunct;
                        state_d   = StWb;
                    end
                    OpcLoad, OpcStore: begin
                        alu_src_b = SrcBImm;
                        alu_op    = AluAdd;
                        state_d   = StMem;
                    end
                    default: begin
                        state_d = StFetch;
                    end
                endcase
            end

            StMem: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = StFetch;
                end
            end

            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StBranch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBReg;
                alu_op     = AluSub;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Counts unanswered request cycles; restarts on any state change or timeout.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || bus_error) begin
            cnt_d = '0;
        end else if (req_phase && !mem_ready && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: cycle-by-cycle vector table plus hand-written
// timeout and mid-operation reset sequences.
module tb_multicycle_control_unit;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    logic        clk, rst, zero, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        mem_to_reg, reg_write, instr_done, illegal, bus_error;
    logic [2:0]  state;
    logic [18:0] obs;

    int n_pass = 0;
    int n_total = 0;

    multicycle_control_unit #(.N(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .instr_done(instr_done), .illegal(illegal), .bus_error(bus_error), .state(state)
    );

    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  alu_op, mem_to_reg, reg_write, instr_done, illegal, bus_error, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        rdy;
        logic [18:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[29];

    function automatic logic [18:0] ev(input logic [2:0] st, input logic req, input logic we,
                                       input logic iod, input logic irw, input logic pcw,
                                       input logic pcs, input logic a, input logic [1:0] b,
                                       input logic [1:0] op, input logic m2r, input logic rw,
                                       input logic done, input logic ill, input logic berr);
        return {req, we, iod, irw, pcw, pcs, a, b, op, m2r, rw, done, ill, berr, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] i, input logic z, input logic r);
        instr     = i;
        zero      = z;
        mem_ready = r;
        @(negedge clk);
    endtask

    task automatic set_vec(input int idx, input logic [31:0] i, input logic z, input logic r,
                           input logic [18:0] e, input string n);
        tbl[idx].instr = i;
        tbl[idx].zero  = z;
        tbl[idx].rdy   = r;
        tbl[idx].exp   = e;
        tbl[idx].name  = n;
    endtask

    logic [18:0] e_idle, e_fetch, e_fwait, e_dec, e_dill, e_exr, e_exi, e_exls;
    logic [18:0] e_memld, e_memst, e_wbr, e_wbld, e_brt, e_brn;

    initial begin
        e_idle  = '0;
        e_fetch = ev(3'd1, 1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        e_fwait = ev(3'd1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        e_dec   = ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        e_dill  = ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 1, 0);
        e_exr   = ev(3'd3, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        e_exi   = ev(3'd3, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0);
        e_exls  = ev(3'd3, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        e_memld = ev(3'd4, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        e_memst = ev(3'd4, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
        e_wbr   = ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
        e_wbld  = ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0, 0);
        e_brt   = ev(3'd6, 0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b01, 0, 0, 1, 0, 0);
        e_brn   = ev(3'd6, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0, 0, 1, 0, 0);

        set_vec(0,  I_ADD,  0, 1, e_idle,  "idle");
        set_vec(1,  I_ADD,  0, 1, e_fetch, "add_fetch");
        set_vec(2,  I_ADD,  0, 1, e_dec,   "add_decode");
        set_vec(3,  I_ADD,  0, 1, e_exr,   "add_exec");
        set_vec(4,  I_ADD,  0, 1, e_wbr,   "add_wb");
        set_vec(5,  I_ADDI, 0, 1, e_fetch, "addi_fetch");
        set_vec(6,  I_ADDI, 0, 0, e_dec,   "addi_decode_rdy_ignored");
        set_vec(7,  I_ADDI, 0, 1, e_exi,   "addi_exec");
        set_vec(8,  I_ADDI, 0, 1, e_wbr,   "addi_wb");
        set_vec(9,  I_LW,   0, 1, e_fetch, "lw_fetch");
        set_vec(10, I_LW,   0, 1, e_dec,   "lw_decode");
        set_vec(11, I_LW,   0, 1, e_exls,  "lw_exec");
        set_vec(12, I_LW,   0, 0, e_memld, "lw_mem_wait1");
        set_vec(13, I_LW,   0, 0, e_memld, "lw_mem_wait2");
        set_vec(14, I_LW,   0, 1, e_memld, "lw_mem_ready");
        set_vec(15, I_LW,   0, 1, e_wbld,  "lw_wb");
        set_vec(16, I_SW,   0, 1, e_fetch, "sw_fetch");
        set_vec(17, I_SW,   0, 1, e_dec,   "sw_decode");
        set_vec(18, I_SW,   0, 1, e_exls,  "sw_exec");
        set_vec(19, I_SW,   0, 1, e_memst, "sw_mem");
        set_vec(20, I_BEQ,  1, 1, e_fetch, "beq_t_fetch");
        set_vec(21, I_BEQ,  1, 1, e_dec,   "beq_t_decode");
        set_vec(22, I_BEQ,  1, 1, e_brt,   "beq_taken");
        set_vec(23, I_BEQ,  0, 1, e_fetch, "beq_n_fetch");
        set_vec(24, I_BEQ,  0, 1, e_dec,   "beq_n_decode");
        set_vec(25, I_BEQ,  0, 1, e_brn,   "beq_not_taken");
        set_vec(26, I_ILL,  0, 1, e_fetch, "ill_fetch");
        set_vec(27, I_ILL,  0, 1, e_dill,  "ill_decode");
        set_vec(28, I_ILL,  0, 0, e_fwait, "ill_back_to_fetch");

        rst = 1'b1;
        instr = '0;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", obs, 19'd0);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            set_in(tbl[i].instr, tbl[i].zero, tbl[i].rdy);
            chk(tbl[i].name, obs, tbl[i].exp);
            adv();
        end

        // Timeout while fetching: fires on the 4th wait cycle and again 4 cycles later.
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_async_fetch", obs, 19'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_in(I_LW, 0, 0);
        chk("to_idle", obs, e_idle);
        adv();
        for (int k = 1; k <= 8; k++) begin
            set_in(I_LW, 0, 0);
            chk($sformatf("fetch_berr_c%0d", k), bus_error, (k == 4 || k == 8));
            chk($sformatf("fetch_state_c%0d", k), state, 3'd1);
            chk($sformatf("fetch_irw_c%0d", k), ir_write, 1'b0);
            adv();
        end

        // Ready arriving on the would-be timeout cycle wins.
        for (int k = 1; k <= 4; k++) begin
            set_in(I_LW, 0, (k == 4));
            chk($sformatf("rdy_wins_berr_c%0d", k), bus_error, 1'b0);
            chk($sformatf("rdy_wins_irw_c%0d", k), ir_write, (k == 4));
            adv();
        end
        set_in(I_LW, 0, 1);
        chk("rdy_wins_decode", state, 3'd2);
        adv();
        set_in(I_LW, 0, 1);
        chk("rdy_wins_exec", state, 3'd3);
        adv();

        // Timeout in MEM aborts the load back to FETCH without a writeback.
        for (int k = 1; k <= 4; k++) begin
            set_in(I_LW, 0, 0);
            chk($sformatf("mem_state_c%0d", k), state, 3'd4);
            chk($sformatf("mem_berr_c%0d", k), bus_error, (k == 4));
            chk($sformatf("mem_rw_c%0d", k), reg_write, 1'b0);
            adv();
        end
        set_in(I_SW, 0, 1);
        chk("mem_to_fetch", obs, e_fetch);
        adv();
        set_in(I_SW, 0, 1);
        adv();
        set_in(I_SW, 0, 1);
        adv();

        // Reset mid-store: outputs drop immediately, no write survives.
        set_in(I_SW, 0, 0);
        chk("st_mem_we", mem_we, 1'b1);
        #1 rst = 1'b1;
        #1 chk("rst_mid_mem_outputs", obs, 19'd0);
        chk("rst_mid_mem_we", mem_we, 1'b0);
        @(posedge clk);
        #1 chk("rst_held_outputs", obs, 19'd0);
        rst = 1'b0;
        set_in(I_SW, 0, 0);
        chk("post_rst_idle", obs, e_idle);
        adv();
        set_in(I_SW, 0, 0);
        chk("post_rst_fetch", obs, e_fwait);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
